imem_fetch_responder: RTL and testbench

Instruction-memory responder for the fetch stage. Accepts the program counter held by the fetch PC latch, issues a fixed-latency word read to the backing instruction memory, and returns the instruction with a one-cycle valid strobe. Holds the upstream PC latch via `stall` while a read is outstanding. Supports flush-abort for redirects.

---
 rtl/imem_fetch_responder_pkg.sv | 14 +
 rtl/fetch_wait_counter.sv | 31 +++
 rtl/imem_fetch_responder.sv | 115 +++++++++++
 tb/tb_imem_fetch_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_responder_pkg.sv
// Shared constants for the instruction-memory fetch responder.
package imem_fetch_responder_pkg;

  // FSM state encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Instruction returned alongside a misalignment fault (addi x0, x0, 0)
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Width of the read-latency counter
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/fetch_wait_counter.sv
// Read-latency counter: loadable, clearable, saturating down-count, flags count==1.
module fetch_wait_counter
  import imem_fetch_responder_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec_en,
  input  logic             clr,
  output logic             last
);

  logic [CNT_W-1:0] count;

  // Count register; stops at zero so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec_en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/imem_fetch_responder.sv
// Fetch-stage instruction-memory responder: fixed-latency word read with
// flush-abort and a one-cycle valid strobe.
// Optional feature macro: IMEM_MISALIGN_TRAP_EN (fault on pc[1:0] != 0).
module imem_fetch_responder
  import imem_fetch_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              req,
  input  logic              flush,
  output logic              stall,
  output logic [ADDR_W-3:0] memAddr,
  output logic              memRdEn,
  input  logic [DATA_W-1:0] memRdData,
  output logic [DATA_W-1:0] instr,
  output logic              instrValid,
  output logic              fault
);

  logic [0:0]        state, state_nxt;
  logic [ADDR_W-3:0] mem_addr_nxt;
  logic              mem_rd_en_nxt;
  logic [DATA_W-1:0] instr_nxt;
  logic              instr_valid_nxt;
  logic              fault_nxt;
  logic              cnt_load, cnt_clr, cnt_dec, cnt_last;
  logic              misaligned;

`ifdef IMEM_MISALIGN_TRAP_EN
  assign misaligned = |pc[1:0];
`else
  logic pc_lsb_unused;
  assign pc_lsb_unused = ^pc[1:0];
  assign misaligned    = 1'b0;
`endif

  // Stall comes straight from the state register, never from inputs.
  assign stall   = (state == ST_WAIT);
  assign cnt_dec = (state == ST_WAIT);

  fetch_wait_counter u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (CNT_W'(WAIT_CYCLES)),
    .dec_en   (cnt_dec),
    .clr      (cnt_clr),
    .last     (cnt_last)
  );

  // Next-state and next-output decode; flush beats completion in WAIT.
  always_comb begin
    state_nxt       = state;
    mem_addr_nxt    = memAddr;
    mem_rd_en_nxt   = 1'b0;
    instr_nxt       = instr;
    instr_valid_nxt = 1'b0;
    fault_nxt       = 1'b0;
    cnt_load        = 1'b0;
    cnt_clr         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req && !flush) begin
          if (misaligned) begin
            fault_nxt = 1'b1;
            instr_nxt = DATA_W'(NOP_INSTR);
          end else begin
            mem_addr_nxt  = pc[ADDR_W-1:2];
            mem_rd_en_nxt = 1'b1;
            cnt_load      = 1'b1;
            state_nxt     = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (flush) begin
          cnt_clr   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (cnt_last) begin
          instr_nxt       = memRdData;
          instr_valid_nxt = 1'b1;
          state_nxt       = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      memAddr    <= '0;
      memRdEn    <= 1'b0;
      instr      <= '0;
      instrValid <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nxt;
      memAddr    <= mem_addr_nxt;
      memRdEn    <= mem_rd_en_nxt;
      instr      <= instr_nxt;
      instrValid <= instr_valid_nxt;
      fault      <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed self-checking bench for imem_fetch_responder (WAIT_CYCLES=2).
module tb_imem_fetch_responder;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        req;
  logic        flush;
  logic        stall;
  logic [29:0] memAddr;
  logic        memRdEn;
  logic [31:0] memRdData;
  logic [31:0] instr;
  logic        instrValid;
  logic        fault;

  int vectors;
  int miscompares;

  imem_fetch_responder #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .WAIT_CYCLES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .req        (req),
    .flush      (flush),
    .stall      (stall),
    .memAddr    (memAddr),
    .memRdEn    (memRdEn),
    .memRdData  (memRdData),
    .instr      (instr),
    .instrValid (instrValid),
    .fault      (fault)
  );

  // Memory model: word contents are C0DE0000 xor word address; memAddr is
  // held through WAIT so the data is stable when it is captured.
  assign memRdData = 32'hC0DE0000 ^ {2'b00, memAddr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    pc    = 32'h0;
    req   = 1'b0;
    flush = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_addr",  32'(memAddr), 32'd0);
    chk("rst_rden",  32'(memRdEn), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", 32'(instrValid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    reset = 1'b0;
    tick();

    // Single fetch at 0x10
    pc  = 32'h10;
    req = 1'b1;
    tick();
    chk("f1_addr",  32'(memAddr), 32'd4);
    chk("f1_rden",  32'(memRdEn), 32'd1);
    chk("f1_stall", 32'(stall), 32'd1);
    chk("f1_valid", 32'(instrValid), 32'd0);
    req = 1'b0;
    tick();
    chk("f1_rden_clr", 32'(memRdEn), 32'd0);
    chk("f1_stall2",   32'(stall), 32'd1);
    chk("f1_valid2",   32'(instrValid), 32'd0);
    tick();
    chk("f1_valid3", 32'(instrValid), 32'd1);
    chk("f1_instr",  instr, 32'hC0DE0004);
    chk("f1_stall3", 32'(stall), 32'd0);
    chk("f1_fault",  32'(fault), 32'd0);
    tick();
    chk("f1_valid_end", 32'(instrValid), 32'd0);
    chk("f1_instr_hold", instr, 32'hC0DE0004);

    // Back-to-back fetches 0x0, 0x4, 0x8 with req held high
    pc  = 32'h0;
    req = 1'b1;
    tick();
    chk("b0_addr", 32'(memAddr), 32'd0);
    chk("b0_rden", 32'(memRdEn), 32'd1);
    tick();
    chk("b0_stall", 32'(stall), 32'd1);
    tick();
    chk("b0_valid", 32'(instrValid), 32'd1);
    chk("b0_instr", instr, 32'hC0DE0000);
    pc = 32'h4;
    tick();
    chk("b1_addr",  32'(memAddr), 32'd1);
    chk("b1_rden",  32'(memRdEn), 32'd1);
    chk("b1_valid", 32'(instrValid), 32'd0);
    tick();
    tick();
    chk("b1_valid2", 32'(instrValid), 32'd1);
    chk("b1_instr",  instr, 32'hC0DE0001);
    pc = 32'h8;
    tick();
    chk("b2_addr", 32'(memAddr), 32'd2);
    tick();
    tick();
    chk("b2_valid", 32'(instrValid), 32'd1);
    chk("b2_instr", instr, 32'hC0DE0002);
    req = 1'b0;
    tick();
    chk("b2_idle_valid", 32'(instrValid), 32'd0);
    chk("b2_idle_stall", 32'(stall), 32'd0);

    // Flush one cycle into WAIT
    pc  = 32'h20;
    req = 1'b1;
    tick();
    chk("fl_stall", 32'(stall), 32'd1);
    chk("fl_addr",  32'(memAddr), 32'd8);
    req   = 1'b0;
    flush = 1'b1;
    tick();
    chk("fl_stall_clr", 32'(stall), 32'd0);
    chk("fl_valid",     32'(instrValid), 32'd0);
    chk("fl_rden",      32'(memRdEn), 32'd0);
    flush = 1'b0;
    tick();
    chk("fl_valid2", 32'(instrValid), 32'd0);
    tick();
    chk("fl_valid3", 32'(instrValid), 32'd0);
    chk("fl_instr",  instr, 32'hC0DE0002);

    // Flush on the completion edge wins
    pc  = 32'h30;
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    chk("flc_valid", 32'(instrValid), 32'd0);
    chk("flc_stall", 32'(stall), 32'd0);
    chk("flc_instr", instr, 32'hC0DE0002);

    // Flush in IDLE drops the request
    pc  = 32'h40;
    req = 1'b1;
    tick();
    chk("fli_rden",  32'(memRdEn), 32'd0);
    chk("fli_stall", 32'(stall), 32'd0);
    req   = 1'b0;
    flush = 1'b0;
    tick();
    chk("fli_valid", 32'(instrValid), 32'd0);

    // Reset mid-WAIT
    pc  = 32'h50;
    req = 1'b1;
    tick();
    chk("rw_stall", 32'(stall), 32'd1);
    req   = 1'b0;
    reset = 1'b1;
    tick();
    chk("rw_stall0", 32'(stall), 32'd0);
    chk("rw_addr0",  32'(memAddr), 32'd0);
    chk("rw_rden0",  32'(memRdEn), 32'd0);
    chk("rw_instr0", instr, 32'd0);
    chk("rw_valid0", 32'(instrValid), 32'd0);
    chk("rw_fault0", 32'(fault), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rw_no_late_valid", 32'(instrValid), 32'd0);
      chk("rw_no_stall", 32'(stall), 32'd0);
    end

    // Misaligned pc = 0x6
    pc  = 32'h6;
    req = 1'b1;
    tick();
`ifdef IMEM_MISALIGN_TRAP_EN
    chk("ma_rden",  32'(memRdEn), 32'd0);
    chk("ma_fault", 32'(fault), 32'd1);
    chk("ma_instr", instr, 32'h00000013);
    chk("ma_valid", 32'(instrValid), 32'd0);
    chk("ma_stall", 32'(stall), 32'd0);
    req = 1'b0;
    tick();
    chk("ma_fault_clr", 32'(fault), 32'd0);
`else
    chk("ma_addr",  32'(memAddr), 32'd1);
    chk("ma_rden",  32'(memRdEn), 32'd1);
    chk("ma_fault", 32'(fault), 32'd0);
    req = 1'b0;
    tick();
    chk("ma_fault2", 32'(fault), 32'd0);
    tick();
    chk("ma_valid", 32'(instrValid), 32'd1);
    chk("ma_instr", instr, 32'hC0DE0001);
    chk("ma_fault3", 32'(fault), 32'd0);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
